// File: rtl/bmu_cnt_pipe_pkg.sv
// Shared BMU definitions for the bit-count pipeline.
package bmu_cnt_pipe_pkg;

  // Count-unit opcodes; 2'b11 is reserved and yields a zero count.
  typedef enum logic [1:0] {
    CPOP     = 2'b00,
    CLZ      = 2'b01,
    CTZ      = 2'b10,
    CNT_RSVD = 2'b11
  } cnt_op_t;

  // Width of the operand slice used by the RV64 word forms.
  localparam int unsigned WORD_W = 32;

endpackage

// File: rtl/bmu_cnt_pipe_popcnt.sv
// BMU building blocks used by the count pipeline: the shared population
// count core and the resettable, enabled flop primitive.

module popcnt #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0]       din,
  output logic [$clog2(WIDTH):0] cnt
);

  localparam int CW = $clog2(WIDTH) + 1;

  // Ripple sum of all set bits; CW bits hold the full-width count.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + CW'(din[i]);
    end
  end

endmodule

module bmu_dffre #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Synchronous clear has priority over the load enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/bmu_cnt_pipe.sv
// Two-stage cpop/clz/ctz unit (with RV64 word forms).
// Stage 1 turns every op into a "count the ones" vector, stage 2 counts it.
import bmu_cnt_pipe_pkg::*;

module bmu_cnt_pipe #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic            w,
  input  logic [XLEN-1:0] a,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  // Bits above the word slice; empty when XLEN is already 32.
  localparam logic [XLEN-1:0] HI_MASK = ~XLEN'(32'hFFFF_FFFF);

  logic            w_eff;
  logic [XLEN-1:0] rev_full;
  logic [31:0]     rev_lo;
  logic [XLEN-1:0] lo_ext;
  logic [XLEN-1:0] x;
  logic [XLEN-1:0] tz_mask;
  logic [XLEN-1:0] p;

  logic            s1_valid;
  logic [XLEN-1:0] s1_p;
  logic            s2_valid;
  logic            s2_adv;
  logic [CW-1:0]   cnt;

  assign w_eff  = (XLEN > WORD_W) ? w : 1'b0;
  assign lo_ext = XLEN'(a[31:0]);

  // Bit reversal of the full operand and of the low word, so clz becomes ctz.
  for (genvar i = 0; i < XLEN; i++) begin : g_rev_full
    assign rev_full[i] = a[XLEN-1-i];
  end
  for (genvar i = 0; i < 32; i++) begin : g_rev_lo
    assign rev_lo[i] = a[31-i];
  end

  // Stage-1 transform: pick x per op, then reduce everything to a popcount.
  // For ctzw/clzw the forced-one upper bits cap the trailing-zero run at 32.
  always_comb begin
    x = a;
    p = '0;
    case (cnt_op_t'(op))
      CPOP:    x = w_eff ? lo_ext : a;
      CTZ:     x = w_eff ? (lo_ext | HI_MASK) : a;
      CLZ:     x = w_eff ? (XLEN'(rev_lo) | HI_MASK) : rev_full;
      default: x = a;
    endcase
    tz_mask = ~x & (x - XLEN'(1));
    case (cnt_op_t'(op))
      CPOP:     p = x;
      CLZ, CTZ: p = tz_mask;
      default:  p = '0;
    endcase
  end

  assign s2_adv    = s1_valid & (~s2_valid | out_ready);
  assign in_ready  = ~s1_valid | s2_adv;
  assign out_valid = s2_valid;

  // Stage-1 valid: reloads whenever the stage can take a new op; flush kills it.
  bmu_dffre #(.WIDTH(1)) u_s1_valid (
    .clk   (clk),
    .reset (reset),
    .en    (flush | in_ready),
    .d     (in_valid & ~flush),
    .q     (s1_valid)
  );

  // Stage-1 data: only captured on an actual transfer, otherwise held.
  bmu_dffre #(.WIDTH(XLEN)) u_s1_data (
    .clk   (clk),
    .reset (reset),
    .en    (in_valid & in_ready),
    .d     (p),
    .q     (s1_p)
  );

  popcnt #(.WIDTH(XLEN)) u_popcnt (
    .din (s1_p),
    .cnt (cnt)
  );

  // Stage-2 valid: refills from stage 1 when empty or being drained.
  bmu_dffre #(.WIDTH(1)) u_s2_valid (
    .clk   (clk),
    .reset (reset),
    .en    (flush | ~s2_valid | out_ready),
    .d     (s1_valid & ~flush),
    .q     (s2_valid)
  );

  // Result register: held stable while the consumer stalls.
  bmu_dffre #(.WIDTH(XLEN)) u_result (
    .clk   (clk),
    .reset (reset),
    .en    (s2_adv),
    .d     (XLEN'(cnt)),
    .q     (result)
  );

endmodule

// File: doc/bmu_cnt_pipe.md
# bmu_cnt_pipe

Two-stage pipelined bit-count unit for the BMU executing cpop/clz/ctz and the RV64 word forms (cpopw/clzw/ctzw). Stage 1 converts the operand into a "count-the-ones" vector so that all three operations reduce to a population count. Stage 2 runs that vector through the existing BMU `popcnt` core and registers the zero-extended count. A valid/ready handshake on both sides lets the unit sit between the operand-issue path and the result writeback path, with back-pressure and flush.

## Interface
- `XLEN`, 64: operand/result width; 32 or 64.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous kill of all in-flight operations.
- `in_valid`  in  1  operand/op presented.
- `in_ready`  out  1  unit accepts this cycle; transfer when `in_valid & in_ready`.
- `op`  in  2  00 cpop, 01 clz, 10 ctz, 11 reserved.
- `w`  in  1  word form: operate on `a[31:0]` only; ignored when XLEN=32.
- `a`  in  XLEN  source operand.
- `out_valid`  out  1  `result` valid.
- `out_ready`  in  1  consumer takes result; transfer when `out_valid & out_ready`.
- `result`  out  XLEN  count, zero-extended.

## Operation
- Stage 1 computes x and then P, registered with `s1_valid`:
  - cpop: x = a, or {zeros, a[31:0]} when `w`.
  - ctz: x = a, or {ones, a[31:0]} when `w`. The upper ones act as a sentinel, so ctzw(0)=32.
  - clz: x = bitreverse(a), or {ones, bitreverse(a[31:0])} when `w`.
  - cpop: P = x. ctz/clz: P = ~x & (x−1), which is the mask of trailing zeros. Subtraction wraps, so x=0 gives all ones.
  - op 11: P = 0, so the result is 0. No error is raised.
- Stage 2 computes `result` = zero-extend(popcnt(P)), registered with `s2_valid` (= `out_valid`).
  - popcnt width is $clog2(XLEN)+1 bits, so max XLEN fits without overflow.
- Advance rules:
  - s2_adv = s1_valid & (!s2_valid | out_ready).
  - `in_ready` = !s1_valid | s2_adv. This is purely combinational from state and `out_ready`; it never depends on `in_valid`.
- Stage registers hold their contents while not advancing.
- `flush`:
  - Clears `s1_valid` and `s2_valid` next edge.
  - Input accepted in the same cycle is discarded.
  - `in_ready` is unaffected by `flush` in that cycle.
- `reset`: clears `s1_valid` and `s2_valid`, sets `result`=0 and stage-1 data=0. Reset takes priority over flush and input.

## Timing
- Latency: accept at edge N gives `out_valid` high after edge N+1, so `result` is visible in cycle N+1→N+2.
- Throughput is one op per cycle with `out_ready` held high.
- Back-pressure (`out_ready`=0, stage 2 full):
  - Stage 1 may still fill.
  - Once both stages are full, `in_ready`=0 until `out_ready` returns.
  - No op is lost or duplicated.
- `result` and `out_valid` are stable while `out_valid & !out_ready`.
- Simultaneous output pop and input push with both stages full: both advance in the same edge.
- Reset mid-operation: all in-flight ops are dropped and `out_valid`=0 the following cycle.
- Outputs after reset: `in_ready`=1, `out_valid`=0, `result`=0.

## Structure
- Opcodes go in the shared BMU package as enum `cnt_op_t`: CPOP=2'b00, CLZ=2'b01, CTZ=2'b10.
- The local bitreverse is a generate loop, not a module.
- Sub-module: reuse `popcnt` with WIDTH=XLEN as the stage-2 counting core.
- Stage flops use the codebase's resettable/enabled flop primitives.

## Test plan
- XLEN=64, ops back-to-back with `out_ready`=1:
  - cpop a=0xFFFF_FFFF_FFFF_FFFF → 64.
  - clz a=0x0000_0000_0000_0001 → 63.
  - ctz a=0x8000_0000_0000_0000 → 63.
  - Results in order on consecutive cycles, 2-cycle latency.
- Zero operand:
  - ctz 0 → 64, clz 0 → 64.
  - ctzw a=0xFFFF_FFFF_0000_0000 → 32.
  - clzw a=0x0000_0000_0000_8000 → 16.
  - cpopw a=0xFFFF_FFFF_0000_000F → 4.
- Back-pressure: hold `out_ready`=0 and issue 3 ops.
  - Two are accepted, then `in_ready`=0.
  - `result` stays stable.
  - On release, 3 results arrive in order.
- `flush` with both stages full and a concurrent `in_valid`: next cycle `out_valid`=0, and no result from those three ops ever appears.
- Reset asserted mid-stream: next cycle `out_valid`=0, `result`=0, `in_ready`=1. A subsequent cpop 0x5 → 2.
- op=11 with any a → result 0, normal latency. At XLEN=32, `w` ignored: ctz 0 → 32.
